mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 115 +++++++++++
 tb/tb_mem_port_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one MEM unit among NREQ requesters, with a timed lock for RMW.
// Grant in 0 cycles, response 1 cycle after handshake; losers and non-owners see ready low.
module mem_port_arbiter #(
   parameter int size     = 32,
   parameter int NREQ     = 4,
   parameter int LOCK_MAX = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ-1:0]      req_we,
   input  logic [NREQ-1:0]      req_lock,
   input  logic [NREQ*size-1:0] req_addr,
   input  logic [NREQ*size-1:0] req_wdata,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [size-1:0]      rsp_rdata,
   output logic [size-1:0]      mem_in0,
   output logic [size-1:0]      mem_in1,
   output logic                 mem_we,
   input  logic [size-1:0]      mem_out0,
   output logic                 lock_timeout
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0]   ptr;
   logic [PW-1:0]   lock_owner;
   logic            locked;
   logic [7:0]      lock_cnt;
   logic [NREQ-1:0] rsp_tag;
   logic            rsp_is_rd;
   logic            timeout_q;

   logic [PW-1:0]   win;
   logic            hs;
   int              idx;

   function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
      return (int'(i) == NREQ-1) ? '0 : i + PW'(1);
   endfunction

   always_comb begin
      win       = '0;
      hs        = 1'b0;
      idx       = 0;
      req_ready = '0;
      if (!reset) begin
         if (locked) begin
            win = lock_owner;
            hs  = req_valid[lock_owner];
         end else begin
            // first valid requester at or after ptr, wrapping around
            for (int k = 0; k < NREQ; k++) begin
               idx = (int'(ptr) + k) % NREQ;
               if (!hs && req_valid[idx]) begin
                  hs  = 1'b1;
                  win = PW'(idx);
               end
            end
         end
         if (hs) req_ready[win] = 1'b1;
      end
   end

   always_comb begin
      mem_in0 = '0;
      mem_in1 = '0;
      mem_we  = 1'b0;
      if (hs) begin
         mem_in0 = req_addr[int'(win)*size +: size];
         mem_in1 = req_wdata[int'(win)*size +: size];
         mem_we  = req_we[win];
      end
   end

   // reset masks the registered outputs so a response pending at reset never shows
   assign rsp_valid    = reset ? '0 : rsp_tag;
   assign rsp_rdata    = (reset || !rsp_is_rd) ? '0 : mem_out0;
   assign lock_timeout = reset ? 1'b0 : timeout_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr        <= '0;
         lock_owner <= '0;
         locked     <= 1'b0;
         lock_cnt   <= '0;
         rsp_tag    <= '0;
         rsp_is_rd  <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         rsp_tag   <= req_ready;
         rsp_is_rd <= hs & ~req_we[win];
         if (locked) begin
            if (hs && !req_lock[win]) begin
               locked <= 1'b0;
               ptr    <= next_idx(lock_owner);
            end else if (lock_cnt >= 8'(LOCK_MAX-1)) begin
               locked    <= 1'b0;
               ptr       <= next_idx(lock_owner);
               timeout_q <= 1'b1;
            end else begin
               lock_cnt <= lock_cnt + 8'd1;
            end
         end else if (hs) begin
            ptr <= next_idx(win);
            if (req_lock[win]) begin
               locked     <= 1'b1;
               lock_owner <= win;
               lock_cnt   <= '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed grant sequences with a response scoreboard; memory returns address ^ RD_KEY.
module tb_mem_port_arbiter;
   localparam logic [31:0] RD_KEY = 32'hA5A5_0000;

   typedef struct {
      logic [3:0]  tag;
      logic [31:0] data;
   } rsp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [3:0]   req_valid = '0;
   logic [3:0]   req_ready;
   logic [3:0]   req_we = '0;
   logic [3:0]   req_lock = '0;
   logic [127:0] req_addr = '0;
   logic [127:0] req_wdata = '0;
   logic [3:0]   rsp_valid;
   logic [31:0]  rsp_rdata;
   logic [31:0]  mem_in0;
   logic [31:0]  mem_in1;
   logic         mem_we;
   logic [31:0]  mem_out0 = '0;
   logic         lock_timeout;

   logic [31:0]  addr_tab  [4];
   logic [31:0]  wdata_tab [4];
   rsp_t         sb[$];
   int           n_chk = 0;
   int           n_fail = 0;

   mem_port_arbiter #(.size(32), .NREQ(4), .LOCK_MAX(16)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_lock(req_lock),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .mem_in0(mem_in0), .mem_in1(mem_in1), .mem_we(mem_we), .mem_out0(mem_out0),
      .lock_timeout(lock_timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) mem_out0 <= mem_in0 ^ RD_KEY;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input string tag, input logic rst, input logic [3:0] v,
                      input logic [3:0] we, input logic [3:0] lk,
                      input logic [3:0] exp_rdy, input logic exp_to);
      rsp_t e;
      @(negedge clk);
      reset = rst;
      if (rst) sb.delete();
      req_valid = v;
      req_we    = we;
      req_lock  = lk;
      for (int i = 0; i < 4; i++) begin
         req_addr[i*32 +: 32]  = addr_tab[i];
         req_wdata[i*32 +: 32] = wdata_tab[i];
      end
      #2;
      chk({tag, ".rdy"}, 32'(req_ready), 32'(exp_rdy));
      chk({tag, ".to"}, 32'(lock_timeout), 32'(exp_to));
      if (exp_rdy == 4'b0000) begin
         chk({tag, ".we0"}, 32'(mem_we), 32'd0);
         chk({tag, ".a0"}, mem_in0, 32'd0);
         chk({tag, ".d0"}, mem_in1, 32'd0);
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (exp_rdy[i]) begin
               chk({tag, ".addr"}, mem_in0, addr_tab[i]);
               chk({tag, ".wdat"}, mem_in1, wdata_tab[i]);
               chk({tag, ".we"}, 32'(mem_we), 32'(we[i]));
               e.tag  = exp_rdy;
               e.data = we[i] ? 32'd0 : (addr_tab[i] ^ RD_KEY);
               sb.push_back(e);
            end
         end
      end
   endtask

   initial begin
      rsp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rsp_vld", 32'(rsp_valid), 32'(e.tag));
            chk("rsp_dat", rsp_rdata, e.data);
         end else begin
            chk("rsp_idle", 32'(rsp_valid), 32'd0);
            chk("rdat_idle", rsp_rdata, 32'd0);
         end
      end
   end

   initial begin
      addr_tab  = '{32'h10, 32'h20, 32'h30, 32'h40};
      wdata_tab = '{32'h1111, 32'h2222, 32'h3333, 32'h4444};

      // reset state, ready forced low even with all requesting
      cyc("rst_a", 1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      cyc("rst_b", 1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0);

      // all four reading: rotate 0,1,2,3
      cyc("rr0", 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 1'b0);
      cyc("rr1", 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 1'b0);
      cyc("rr2", 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 1'b0);
      cyc("rr3", 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 1'b0);
      cyc("rr_idle", 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

      // single write by requester 2, then pointer sits at 3
      cyc("rst_c", 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      addr_tab[2]  = 32'h5;
      wdata_tab[2] = 32'hDEAD;
      cyc("wr2", 1'b0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0);
      cyc("after_wr", 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 1'b0);
      cyc("wrap0", 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 1'b0);
      cyc("idle2", 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

      // requester 1 lock: read, renew, owner idle, write-release, then 2 wins
      addr_tab[1] = 32'h8;
      cyc("lk_entry", 1'b0, 4'b1111, 4'b0000, 4'b0010, 4'b0010, 1'b0);
      cyc("lk_renew", 1'b0, 4'b1111, 4'b0000, 4'b0010, 4'b0010, 1'b0);
      cyc("lk_hold", 1'b0, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      cyc("lk_rel", 1'b0, 4'b1111, 4'b0010, 4'b0000, 4'b0010, 1'b0);
      cyc("post_rel", 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 1'b0);
      cyc("idle3", 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

      // requester 0 locks and idles: 16 locked cycles, then timeout with 1 granted
      cyc("to_entry", 1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 1'b0);
      for (int k = 0; k < 16; k++)
         cyc($sformatf("to_wait%0d", k), 1'b0, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      cyc("to_pulse", 1'b0, 4'b1110, 4'b0000, 4'b0000, 4'b0010, 1'b1);
      cyc("to_after", 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

      // reset the cycle after a read: response dropped, arbitration restarts at 0
      cyc("pre_rst", 1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b0);
      cyc("mid_rst_a", 1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      cyc("mid_rst_b", 1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      cyc("restart", 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 1'b0);
      cyc("idle5", 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

      // release in the timeout cycle: no pulse, next grant after owner 3 is 0
      cyc("rt_entry", 1'b0, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 1'b0);
      for (int k = 0; k < 15; k++)
         cyc($sformatf("rt_wait%0d", k), 1'b0, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      cyc("rt_rel", 1'b0, 4'b1111, 4'b1000, 4'b0000, 4'b1000, 1'b0);
      cyc("rt_after", 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 1'b0);
      cyc("idle6", 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

      @(negedge clk);
      #3;
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
